ysyx_22040125_alu_arb: RTL and testbench

YSYX_22040125_ALU_ARB -- requirements
Module: ysyx_22040125_alu_arb

---
 rtl/ysyx_22040125_alu_arb_pkg.sv | 41 ++++
 rtl/ysyx_22040125_ALU.sv | 54 +++++
 rtl/ysyx_22040125_alu_arb.sv | 108 ++++++++++
 tb/tb_ysyx_22040125_alu_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_alu_arb_pkg.sv
// Shared constants and payload types for the ex/ls ALU arbiter.
//   - op-bit indices of the one-hot ALU op vector
//   - requester id encoding returned on res_id
//   - default tag width and datapath widths
package ysyx_22040125_alu_arb_pkg;

  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned OP_W      = 12;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BHWD_W    = 3;

  // One-hot op bit positions
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 5;
  localparam int unsigned OP_SRL  = 6;
  localparam int unsigned OP_SRA  = 7;
  localparam int unsigned OP_SLT  = 8;
  localparam int unsigned OP_SLTU = 9;
  localparam int unsigned OP_LUI  = 10;
  localparam int unsigned OP_JAL  = 11;

  // Requester id encoding
  localparam logic ID_EX = 1'b0;
  localparam logic ID_LS = 1'b1;

  // Operation payload offered by a requester
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   imm;
    logic [BHWD_W-1:0] s_bhwd;
    logic              s_check;
  } alu_req_t;

endpackage

// File: rtl/ysyx_22040125_ALU.sv
// Combinational ALU shared by the ex and ls requesters.
//   req      : op (one-hot), operands, store-replicate select, addr-gen mode
//   data_rd  : OR of the results of every selected op (0 when op == 0)
//   src2_rep : src2 replicated per s_bhwd (100 byte, 010 half, 001 word)
//   addr     : low 32 bits of src1 + (s_check ? imm : src2)
module ysyx_22040125_ALU
  import ysyx_22040125_alu_arb_pkg::*;
(
  input  alu_req_t          req,
  output logic [XLEN-1:0]   data_rd,
  output logic [XLEN-1:0]   src2_rep,
  output logic [ADDR_W-1:0] addr
);

  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] sum;
  logic [5:0]      shamt;
  logic [XLEN-1:0] res [OP_W];

  // Per-op results, then an AND-OR select so malformed ops still yield data
  always_comb begin
    opb   = req.s_check ? req.imm : req.src2;
    sum   = req.src1 + opb;
    shamt = opb[5:0];
    res[OP_ADD]  = sum;
    res[OP_SUB]  = req.src1 - opb;
    res[OP_AND]  = req.src1 & opb;
    res[OP_OR]   = req.src1 | opb;
    res[OP_XOR]  = req.src1 ^ opb;
    res[OP_SLL]  = req.src1 << shamt;
    res[OP_SRL]  = req.src1 >> shamt;
    res[OP_SRA]  = XLEN'($signed(req.src1) >>> shamt);
    res[OP_SLT]  = XLEN'($signed(req.src1) < $signed(opb));
    res[OP_SLTU] = XLEN'(req.src1 < opb);
    res[OP_LUI]  = req.imm;
    res[OP_JAL]  = req.src1 + XLEN'(4);
    data_rd = '0;
    for (int i = 0; i < int'(OP_W); i++) begin
      if (req.op[i]) data_rd = data_rd | res[i];
    end
    addr = sum[ADDR_W-1:0];
  end

  // Store-data lane replication
  always_comb begin
    case (req.s_bhwd)
      3'b100:  src2_rep = {8{req.src2[7:0]}};
      3'b010:  src2_rep = {4{req.src2[15:0]}};
      3'b001:  src2_rep = {2{req.src2[31:0]}};
      default: src2_rep = req.src2;
    endcase
  end

endmodule

// File: rtl/ysyx_22040125_alu_arb.sv
// Round-robin arbiter sharing one ALU between the ex and ls requesters,
// with a single registered result slot (latency 1, no bubble on drain+accept).
//   ex_* / ls_* : valid/ready request channels carrying op, operands and tag
//   res_*       : registered result channel (data, store data, addr, id, tag, err)
module ysyx_22040125_alu_arb
  import ysyx_22040125_alu_arb_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [XLEN-1:0]   ex_src1,
  input  logic [XLEN-1:0]   ex_src2,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [BHWD_W-1:0] ex_s_bhwd,
  input  logic              ex_s_check,
  input  logic [TAG_W-1:0]  ex_tag,
  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic [OP_W-1:0]   ls_op,
  input  logic [XLEN-1:0]   ls_src1,
  input  logic [XLEN-1:0]   ls_src2,
  input  logic [XLEN-1:0]   ls_imm,
  input  logic [BHWD_W-1:0] ls_s_bhwd,
  input  logic              ls_s_check,
  input  logic [TAG_W-1:0]  ls_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [XLEN-1:0]   res_data,
  output logic [XLEN-1:0]   res_src2,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_id,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err
);

  logic              last_id;
  logic              can_accept;
  logic              grant_ex;
  logic              grant_ls;
  logic              accept;
  alu_req_t          sel_req;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_err;
  logic [XLEN-1:0]   alu_data;
  logic [XLEN-1:0]   alu_src2;
  logic [ADDR_W-1:0] alu_addr;

  // Grant: sole valid wins; on a tie the requester not granted last wins
  always_comb begin
    can_accept = rst_n & (~res_valid | res_ready);
    grant_ex   = ex_valid & (~ls_valid | (last_id == ID_LS));
    grant_ls   = ls_valid & ~grant_ex;
    ex_ready   = can_accept & grant_ex;
    ls_ready   = can_accept & grant_ls;
    accept     = (ex_valid & ex_ready) | (ls_valid & ls_ready);
  end

  // Operand mux in front of the shared ALU
  always_comb begin
    if (grant_ls) begin
      sel_req = '{op: ls_op, src1: ls_src1, src2: ls_src2, imm: ls_imm,
                  s_bhwd: ls_s_bhwd, s_check: ls_s_check};
      sel_tag = ls_tag;
    end else begin
      sel_req = '{op: ex_op, src1: ex_src1, src2: ex_src2, imm: ex_imm,
                  s_bhwd: ex_s_bhwd, s_check: ex_s_check};
      sel_tag = ex_tag;
    end
    sel_err = ($countones(sel_req.op) != 1) & ~sel_req.s_check;
  end

  ysyx_22040125_ALU u_alu (
    .req      (sel_req),
    .data_rd  (alu_data),
    .src2_rep (alu_src2),
    .addr     (alu_addr)
  );

  // Result slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_src2  <= '0;
      res_addr  <= '0;
      res_id    <= ID_EX;
      res_tag   <= '0;
      res_err   <= 1'b0;
      last_id   <= ID_LS;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= alu_data;
      res_src2  <= alu_src2;
      res_addr  <= alu_addr;
      res_id    <= grant_ls ? ID_LS : ID_EX;
      res_tag   <= sel_tag;
      res_err   <= sel_err;
      last_id   <= grant_ls ? ID_LS : ID_EX;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_alu_arb.sv
// Self-checking bench for ysyx_22040125_alu_arb: directed scenarios followed
// by constrained-random traffic, compared against a behavioural model.
module tb_ysyx_22040125_alu_arb;

  localparam int unsigned TW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ls_valid, ex_ready, ls_ready;
  logic [11:0] ex_op, ls_op;
  logic [63:0] ex_src1, ex_src2, ex_imm, ls_src1, ls_src2, ls_imm;
  logic [2:0]  ex_s_bhwd, ls_s_bhwd;
  logic        ex_s_check, ls_s_check;
  logic [TW-1:0] ex_tag, ls_tag;
  logic        res_valid, res_ready, res_id, res_err;
  logic [63:0] res_data, res_src2;
  logic [31:0] res_addr;
  logic [TW-1:0] res_tag;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_valid, m_id, m_err, m_last_ls;
  logic [63:0] m_data, m_src2;
  logic [31:0] m_addr;
  logic [TW-1:0] m_tag;
  logic        acc_ex, acc_ls;

  always #5 clk = ~clk;

  ysyx_22040125_alu_arb #(.TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_s_bhwd(ex_s_bhwd),
    .ex_s_check(ex_s_check), .ex_tag(ex_tag),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_op(ls_op), .ls_src1(ls_src1),
    .ls_src2(ls_src2), .ls_imm(ls_imm), .ls_s_bhwd(ls_s_bhwd),
    .ls_s_check(ls_s_check), .ls_tag(ls_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src2(res_src2), .res_addr(res_addr), .res_id(res_id),
    .res_tag(res_tag), .res_err(res_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value of a single ALU operation, by op index
  function automatic logic [63:0] op_value(input int idx, input logic [63:0] a,
                                           input logic [63:0] b, input logic [63:0] imm);
    case (idx)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << b[5:0];
      6:  return a >> b[5:0];
      7:  return 64'($signed(a) >>> b[5:0]);
      8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      9:  return (a < b) ? 64'd1 : 64'd0;
      10: return imm;
      default: return a + 64'd4;
    endcase
  endfunction

  task automatic model_load(input logic [11:0] op, input logic [63:0] s1,
                            input logic [63:0] s2, input logic [63:0] imm,
                            input logic [2:0] bhwd, input logic chkm,
                            input logic [TW-1:0] tag, input logic id);
    logic [63:0] b, d, sum;
    int ones;
    b = chkm ? imm : s2;
    d = 64'd0;
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      if (op[i]) begin
        d = d | op_value(i, s1, b, imm);
        ones++;
      end
    end
    sum = s1 + b;
    m_valid = 1'b1;
    m_data  = d;
    m_addr  = sum[31:0];
    case (bhwd)
      3'b100:  m_src2 = {8{s2[7:0]}};
      3'b010:  m_src2 = {4{s2[15:0]}};
      3'b001:  m_src2 = {2{s2[31:0]}};
      default: m_src2 = s2;
    endcase
    m_id      = id;
    m_tag     = tag;
    m_err     = (ones != 1) && !chkm;
    m_last_ls = id;
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src2 = 0; m_addr = 0;
    m_id = 0; m_tag = 0; m_err = 0; m_last_ls = 1'b1;
  endtask

  task automatic check_res();
    chk("res_valid", 64'(res_valid), 64'(m_valid));
    chk("res_data",  res_data, m_data);
    chk("res_src2",  res_src2, m_src2);
    chk("res_addr",  64'(res_addr), 64'(m_addr));
    chk("res_id",    64'(res_id), 64'(m_id));
    chk("res_tag",   64'(res_tag), 64'(m_tag));
    chk("res_err",   64'(res_err), 64'(m_err));
  endtask

  // One clock: check readies, advance model on the edge, check results
  task automatic cycle();
    logic can, g_ex, g_ls;
    #1;
    can  = rst_n && (!m_valid || res_ready);
    g_ex = ex_valid && (!ls_valid || m_last_ls);
    g_ls = ls_valid && !g_ex;
    acc_ex = can && g_ex;
    acc_ls = can && g_ls;
    chk("ex_ready", 64'(ex_ready), 64'(acc_ex));
    chk("ls_ready", 64'(ls_ready), 64'(acc_ls));
    @(posedge clk);
    if (acc_ex)
      model_load(ex_op, ex_src1, ex_src2, ex_imm, ex_s_bhwd, ex_s_check, ex_tag, 1'b0);
    else if (acc_ls)
      model_load(ls_op, ls_src1, ls_src2, ls_imm, ls_s_bhwd, ls_s_check, ls_tag, 1'b1);
    else if (res_ready)
      m_valid = 1'b0;
    #1;
    check_res();
    @(negedge clk);
  endtask

  task automatic rand_req(output logic [11:0] op, output logic [63:0] s1,
                          output logic [63:0] s2, output logic [63:0] imm,
                          output logic [2:0] bhwd, output logic chkm,
                          output logic [TW-1:0] tag);
    logic [11:0] one;
    one = 12'b1;
    op = ($urandom_range(0, 7) == 0) ? 12'($urandom) : (one << $urandom_range(0, 11));
    s1   = {$urandom, $urandom};
    s2   = {$urandom, $urandom};
    imm  = {$urandom, $urandom};
    bhwd = 3'($urandom_range(0, 7));
    chkm = ($urandom_range(0, 3) == 0);
    tag  = TW'($urandom);
  endtask

  logic [63:0] hold_data;

  initial begin
    rst_n = 0; res_ready = 0;
    ex_valid = 0; ex_op = 0; ex_src1 = 0; ex_src2 = 0; ex_imm = 0;
    ex_s_bhwd = 0; ex_s_check = 0; ex_tag = 0;
    ls_valid = 0; ls_op = 0; ls_src1 = 0; ls_src2 = 0; ls_imm = 0;
    ls_s_bhwd = 0; ls_s_check = 0; ls_tag = 0;
    model_reset();
    acc_ex = 0; acc_ls = 0;
    repeat (2) @(negedge clk);
    check_res();
    rst_n = 1;

    // Round-robin under continuous contention
    ex_valid = 1; ex_op = 12'h001; ex_src1 = 64'd1; ex_src2 = 64'd2; ex_tag = 4'h3;
    ls_valid = 1; ls_op = 12'h004; ls_src1 = 64'hF0; ls_src2 = 64'h3C; ls_tag = 4'hA;
    res_ready = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_order", 64'(res_id), 64'(k % 2));
    end
    ex_valid = 0; ls_valid = 0;
    cycle();

    // ex add 5 + 7
    ex_valid = 1; ex_op = 12'h001; ex_src1 = 64'd5; ex_src2 = 64'd7; ex_s_check = 0;
    cycle();
    chk("add_valid", 64'(res_valid), 64'd1);
    chk("add_data", res_data, 64'd12);
    chk("add_id", 64'(res_id), 64'd0);

    // Backpressure: nothing accepted, result held
    ex_op = 12'h010; ex_src2 = 64'd3; ls_valid = 1; res_ready = 0;
    hold_data = res_data;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 64'({ex_ready, ls_ready}), 64'd0);
      cycle();
      chk("stall_hold", res_data, hold_data);
    end
    res_ready = 1;
    #1;
    chk("drain_accept", 64'(ls_ready), 64'd1);
    cycle();
    ex_valid = 0;
    cycle();

    // ls store address generation and byte replication
    ls_valid = 1; ls_op = 12'h001; ls_s_check = 1; ls_src1 = 64'h8000_0000;
    ls_imm = 64'h10; ls_src2 = 64'hAB; ls_s_bhwd = 3'b100; ls_tag = 4'h5;
    cycle();
    chk("st_addr", 64'(res_addr), 64'h8000_0010);
    chk("st_src2", res_src2, 64'hABAB_ABAB_ABAB_ABAB);
    chk("st_id", 64'(res_id), 64'd1);
    ls_valid = 0; ls_s_check = 0;

    // Malformed ops are flagged, not dropped
    ex_valid = 1; ex_op = 12'h003; ex_s_check = 0;
    cycle();
    chk("err_two_hot", 64'(res_err), 64'd1);
    chk("err_two_hot_v", 64'(res_valid), 64'd1);
    ex_op = 12'h000;
    cycle();
    chk("err_zero", 64'(res_err), 64'd1);

    // Asynchronous reset mid-operation
    ex_op = 12'h001;
    cycle();
    chk("pre_rst_valid", 64'(res_valid), 64'd1);
    rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_valid", 64'(res_valid), 64'd0);
    chk("async_rst_data", res_data, 64'd0);
    ls_valid = 1;
    cycle();
    rst_n = 1;
    cycle();
    chk("post_rst_tie", 64'(res_id), 64'd0);

    // Randomized traffic; requesters hold inputs until accepted
    for (int n = 0; n < 400; n++) begin
      if (!ex_valid || acc_ex) begin
        ex_valid = ($urandom_range(0, 3) != 0);
        rand_req(ex_op, ex_src1, ex_src2, ex_imm, ex_s_bhwd, ex_s_check, ex_tag);
      end
      if (!ls_valid || acc_ls) begin
        ls_valid = ($urandom_range(0, 3) != 0);
        rand_req(ls_op, ls_src1, ls_src2, ls_imm, ls_s_bhwd, ls_s_check, ls_tag);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
